// File: rtl/updown_counter_param.sv
// Up/down counter stepped by an internal clock-enable prescaler, with
// synchronous load, wrap/saturate limit handling and a registered terminal-count pulse.
module updown_counter_param #(
    parameter int WIDTH = 4,
    parameter int DIV   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0] pre;
    logic             at_limit;
    logic [WIDTH-1:0] stepped;

    // Gated by rst so the strobe drops the instant reset asserts.
    assign tick = en & ~rst & (pre == PRE_MAX);

    // Plain modulo arithmetic already yields the wrapped value at a limit.
    always_comb begin
        at_limit = mode ? (count == CNT_MAX) : (count == '0);
        stepped  = mode ? count + 1'b1 : count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (load || tick) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
        end else if (tick) begin
            tc    <= at_limit;
            count <= (at_limit && sat) ? count : stepped;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter with a built-in clock-enable prescaler, synchronous parallel load, and selectable wrap or saturate behaviour at the count limits. It replaces divided-clock counters: the whole block runs on the single system clock, and a prescaler tick gates each count step. A registered terminal-count pulse lets downstream logic (display drivers, cascaded counters) react to wrap or limit events.

## Interface

- `WIDTH`, default 4: count width in bits. Must be ≥ 1.
- `DIV`, default 25000000: prescaler divisor, giving one count step per `DIV` enabled clock cycles. Must be ≥ 1.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: count enable; gates both the prescaler and the counter.
- `mode`  in  1: direction; 1 = up, 0 = down.
- `sat`  in  1: limit behaviour; 1 = saturate at the limits, 0 = wrap.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value written to `count` on `load`.
- `count`  out  WIDTH: registered counter value.
- `tick`  out  1: prescaler step strobe (combinational).
- `tc`  out  1: registered terminal-count pulse.

## Operation

- Prescaler `pre` is an internal counter of width clog2(DIV), minimum 1 bit.
  - `tick = en & (pre == DIV-1)`; forced to 0 while `rst` is high.
  - When `en` is high: `pre` increments, and returns to 0 on the cycle after `tick`.
  - When `en` is low: `pre` holds.
- Per rising edge, evaluated in priority order:
  1. **`load`** (regardless of `en`): `count <= load_val`, `pre <= 0`, `tc <= 0`.
  2. **`tick`, up** (`mode` = 1):
     - `count` < 2^WIDTH−1: `count <= count+1`, `tc <= 0`.
     - `count` = 2^WIDTH−1: `tc <= 1`; `count <= 0` if `sat` = 0, else `count` holds.
  3. **`tick`, down** (`mode` = 0):
     - `count` > 0: `count <= count−1`, `tc <= 0`.
     - `count` = 0: `tc <= 1`; `count <= 2^WIDTH−1` if `sat` = 0, else `count` holds.
  4. **Otherwise:** `count` holds, `tc <= 0`.
- `mode` and `sat` are sampled only on tick cycles. Changing them mid-prescale does not reset `pre`.
- In saturate mode, `tc` pulses on every tick taken at the limit, not just the first.
- All arithmetic is modulo 2^WIDTH. There is no sign interpretation.

## Timing

- Reset values (asynchronous, applied immediately without a clock edge): `count` = 0, `pre` = 0, `tc` = 0, `tick` = 0.
- First step after reset release with `en` held high:
  - `tick` is high in cycle DIV−1 (cycles counted from the first edge after release).
  - The new `count` is visible in cycle DIV.
  - Subsequent steps follow every DIV cycles.
- `tc` is high for exactly the one cycle in which `count` shows the post-limit value (wrapped or held). Latency from the `tick` cycle is one clock.
- DIV = 1: `tick` = `en`, and `count` steps every enabled cycle.
- `load` coinciding with `tick`: the load wins, the step is discarded, and the next tick comes DIV enabled cycles later.
- `rst` asserted mid-prescale or mid-pulse: all state clears at once. Counting restarts from `pre` = 0 after release.
- `en` deasserted on a `tick` cycle: no step that cycle. `pre` holds at DIV−1, so the tick fires again on the first cycle `en` is re-asserted.

## Test plan

Scenarios 1–5 use WIDTH = 4, DIV = 4.

1. **Asynchronous reset.** Run to `count` = 5, then assert `rst` between clock edges → `count` = 0 and `tc` = 0 before the next edge. After release with `en` = 1, `count` = 1 is visible 4 cycles later.
2. **Up wrap.** `load_val` = 14, pulse `load`, then `mode` = 1, `sat` = 0, `en` = 1 → `count` goes 14, 15, 0, 1 with steps 4 cycles apart. `tc` is high for one cycle, concurrent with `count` = 0.
3. **Down saturate.** Load 1, `mode` = 0, `sat` = 1 → `count` goes 1, 0, 0, 0. `tc` = 0 on the 1→0 step, and `tc` pulses one cycle on each subsequent tick while `count` stays 0.
4. **Load vs tick collision.** Assert `load` with `load_val` = 9 in the same cycle as `tick` → `count` = 9, no step taken. The next change (to 10, `mode` = 1) occurs exactly 4 cycles later.
5. **Enable and direction gating.** Drop `en` for 10 cycles mid-prescale → `count`, `pre` and `tc` hold. Toggle `mode` while `en` is low → no effect until the next tick. Re-enable → the step resumes from the held `pre` phase.
6. **Parameter corners.** WIDTH = 8, DIV = 1, wrap mode, down from 0 → `count` = 255 on the first enabled edge, with `tc` high that cycle. Then it decrements every cycle.
